// File: rtl/ledcal_pkg.sv
// rtl/ledcal_pkg.sv - shared states, default constants and midpoint helper for the LED channel calibrator
//
// Purpose : common definitions imported by led_channel_calibrator.
// Contents: state_e (controller states), DEF_* default parameter values,
//           midpoint() computing (a+b)>>1 with one extra bit of headroom.
package ledcal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DC_ACC,
    DC_ADJ,
    PGA_ACC,
    PGA_ADJ,
    NEXT_CH,
    RUN
  } state_e;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_ADC_W    = 8;
  localparam int DEF_DC_W     = 7;
  localparam int DEF_PGA_W    = 4;
  localparam int DEF_DC_INIT  = 64;
  localparam int DEF_DC_WIN   = 10;
  localparam int DEF_PGA_WIN  = 50;
  localparam int DEF_DC_LO    = 110;
  localparam int DEF_DC_HI    = 140;
  localparam int DEF_CLIP_LO  = 5;
  localparam int DEF_CLIP_HI  = 250;
  localparam int DEF_SLOT_LEN = 10;

  // Widest sample the midpoint helper handles; narrower samples are zero-extended.
  localparam int MID_W = 16;

  // The sum is formed one bit wider than the samples so max+min cannot overflow.
  function automatic logic [MID_W:0] midpoint(input logic [MID_W-1:0] a,
                                              input logic [MID_W-1:0] b);
    logic [MID_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum >> 1;
  endfunction

endpackage

// File: rtl/window_minmax.sv
// rtl/window_minmax.sv - running min/max of ADC samples over a window of win_len_i samples
//
// Purpose : tracks minimum and maximum of the samples taken while enable_i is high
//           and flags the last sample of the window.
// Ports   : clk_i, rst_i    - clock, asynchronous active-high reset
//           adc_i           - sample
//           clear_i         - restart window (min to all-ones, max to zero, count to zero)
//           enable_i        - take adc_i this cycle
//           win_len_i       - samples per window
//           min_o / max_o   - extremes seen so far in the window
//           done_o          - high on the cycle the final window sample is taken
module window_minmax #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] adc_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [CNT_W-1:0]  win_len_i,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic              done_o
);

  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign done_o = enable_i && (cnt_q == (win_len_i - CNT_W'(1)));
  assign min_o  = min_q;
  assign max_o  = max_q;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      min_d = '1;
      max_d = '0;
      cnt_d = '0;
    end else if (enable_i) begin
      // Min and max are independent: a single sample can move both.
      if (adc_i < min_q) min_d = adc_i;
      if (adc_i > max_q) max_d = adc_i;
      cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_channel_calibrator.sv
// rtl/led_channel_calibrator.sv - DC/PGA calibration and round-robin sampling of NUM_CH LED channels
//
// Purpose : per channel, steps the DC compensation code until the signal midpoint sits in
//           [DC_LO, DC_HI], then raises PGA gain until clipping or full scale; afterwards
//           cycles through the channels applying stored settings and capturing one sample
//           per slot.
// Ports   : CLK, rst            - clock, asynchronous active-high reset
//           ADC                 - current sample
//           Find_setting        - start (or restart from RUN) calibration
//           LED_EN              - one-hot LED drive, zero when idle
//           DC_Comp, PGA_Gain   - applied DC and gain codes
//           CLK_Filter          - CLK divided by two
//           Ch_Value            - last captured sample per channel, channel k at [k*ADC_W +: ADC_W]
//           Value_valid         - per-channel pulse when Ch_Value updates
//           Cal_done            - high in RUN
//           Cal_err             - DC code saturated during that channel's calibration
//           Busy                - high during calibration
module led_channel_calibrator
  import ledcal_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADC_W    = DEF_ADC_W,
  parameter int DC_W     = DEF_DC_W,
  parameter int PGA_W    = DEF_PGA_W,
  parameter int DC_INIT  = DEF_DC_INIT,
  parameter int DC_WIN   = DEF_DC_WIN,
  parameter int PGA_WIN  = DEF_PGA_WIN,
  parameter int DC_LO    = DEF_DC_LO,
  parameter int DC_HI    = DEF_DC_HI,
  parameter int CLIP_LO  = DEF_CLIP_LO,
  parameter int CLIP_HI  = DEF_CLIP_HI,
  parameter int SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [ADC_W-1:0]        ADC,
  input  logic                    Find_setting,
  output logic [NUM_CH-1:0]       LED_EN,
  output logic [DC_W-1:0]         DC_Comp,
  output logic [PGA_W-1:0]        PGA_Gain,
  output logic                    CLK_Filter,
  output logic [NUM_CH*ADC_W-1:0] Ch_Value,
  output logic [NUM_CH-1:0]       Value_valid,
  output logic                    Cal_done,
  output logic [NUM_CH-1:0]       Cal_err,
  output logic                    Busy
);

  localparam int CNT_W  = $clog2(((DC_WIN > PGA_WIN) ? DC_WIN : PGA_WIN) + 1);
  localparam int SLOT_W = $clog2(SLOT_LEN);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [NUM_CH-1:0] LED_ONE   = NUM_CH'(1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] SLOT_CAP  = SLOT_W'(SLOT_LEN - 2);
  localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(SLOT_LEN - 1);
  localparam logic [DC_W-1:0]   DC_INIT_C = DC_W'(DC_INIT);
  localparam logic [MID_W:0]    AVG_LO    = (MID_W + 1)'(DC_LO);
  localparam logic [MID_W:0]    AVG_HI    = (MID_W + 1)'(DC_HI);
  localparam logic [ADC_W-1:0]  CLIP_LO_C = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0]  CLIP_HI_C = ADC_W'(CLIP_HI);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [DC_W-1:0]         dc_comp_q, dc_comp_d;
  logic [PGA_W-1:0]        pga_q, pga_d;
  logic [NUM_CH-1:0]       led_q, led_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [NUM_CH*ADC_W-1:0] ch_value_q, ch_value_d;
  logic [NUM_CH-1:0]       valid_q, valid_d;
  logic [NUM_CH-1:0]       cal_err_q, cal_err_d;
  logic                    busy_q, busy_d;
  logic                    cal_done_q, cal_done_d;
  logic                    clk_filter_q;
  logic [DC_W-1:0]         dc_q   [NUM_CH];
  logic [DC_W-1:0]         dc_d   [NUM_CH];
  logic [PGA_W-1:0]        gain_q [NUM_CH];
  logic [PGA_W-1:0]        gain_d [NUM_CH];

  logic                    start;
  logic                    win_en;
  logic                    win_done;
  logic [CNT_W-1:0]        win_len;
  logic [ADC_W-1:0]        win_min;
  logic [ADC_W-1:0]        win_max;
  logic [MID_W:0]          avg;
  logic [CH_W-1:0]         ch_inc;
  logic [CH_W-1:0]         ch_run_nxt;

  // One window tracker serves both phases; it is held clear outside the
  // accumulate states, so each DC/PGA evaluation starts from an empty window.
  assign win_en  = (state_q == DC_ACC) || (state_q == PGA_ACC);
  assign win_len = (state_q == PGA_ACC) ? CNT_W'(PGA_WIN) : CNT_W'(DC_WIN);

  window_minmax #(
    .DATA_W (ADC_W),
    .CNT_W  (CNT_W)
  ) u_window (
    .clk_i     (CLK),
    .rst_i     (rst),
    .adc_i     (ADC),
    .clear_i   (!win_en),
    .enable_i  (win_en),
    .win_len_i (win_len),
    .min_o     (win_min),
    .max_o     (win_max),
    .done_o    (win_done)
  );

  assign avg        = midpoint(MID_W'(win_max), MID_W'(win_min));
  assign ch_inc     = ch_q + CH_W'(1);
  assign ch_run_nxt = (ch_q == LAST_CH) ? '0 : ch_inc;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dc_comp_d  = dc_comp_q;
    pga_d      = pga_q;
    led_d      = led_q;
    slot_d     = slot_q;
    ch_value_d = ch_value_q;
    valid_d    = '0;
    cal_err_d  = cal_err_q;
    dc_d       = dc_q;
    gain_d     = gain_q;
    start      = 1'b0;

    case (state_q)
      IDLE: start = Find_setting;

      DC_ACC: if (win_done) state_d = DC_ADJ;

      DC_ADJ: begin
        if (avg < AVG_LO) begin
          if (dc_comp_q == '0) begin
            // Code cannot go lower: keep it, flag the channel and move on.
            cal_err_d[ch_q] = 1'b1;
            dc_d[ch_q]      = dc_comp_q;
            state_d         = PGA_ACC;
          end else begin
            dc_comp_d = dc_comp_q - DC_W'(1);
            state_d   = DC_ACC;
          end
        end else if (avg > AVG_HI) begin
          if (dc_comp_q == '1) begin
            cal_err_d[ch_q] = 1'b1;
            dc_d[ch_q]      = dc_comp_q;
            state_d         = PGA_ACC;
          end else begin
            dc_comp_d = dc_comp_q + DC_W'(1);
            state_d   = DC_ACC;
          end
        end else begin
          dc_d[ch_q] = dc_comp_q;
          state_d    = PGA_ACC;
        end
      end

      PGA_ACC: if (win_done) state_d = PGA_ADJ;

      PGA_ADJ: begin
        if ((win_min <= CLIP_LO_C) || (win_max >= CLIP_HI_C)) begin
          // Current gain clips: settle on the previous step.
          gain_d[ch_q] = (pga_q == '0) ? '0 : pga_q - PGA_W'(1);
          state_d      = NEXT_CH;
        end else if (pga_q == '1) begin
          gain_d[ch_q] = pga_q;
          state_d      = NEXT_CH;
        end else begin
          pga_d   = pga_q + PGA_W'(1);
          state_d = PGA_ACC;
        end
      end

      NEXT_CH: begin
        if (ch_q == LAST_CH) begin
          state_d   = RUN;
          ch_d      = '0;
          slot_d    = '0;
          led_d     = LED_ONE;
          dc_comp_d = dc_d[0];
          pga_d     = gain_d[0];
        end else begin
          state_d   = DC_ACC;
          ch_d      = ch_inc;
          led_d     = LED_ONE << ch_inc;
          dc_comp_d = DC_INIT_C;
          pga_d     = '0;
        end
      end

      RUN: begin
        start = Find_setting;
        // Capture one cycle before the slot ends so Ch_Value and Value_valid
        // are presented during the slot's last cycle, with the LED still on.
        if (slot_q == SLOT_CAP) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
              ch_value_d[k*ADC_W +: ADC_W] = ADC;
              valid_d[k]                   = 1'b1;
            end
          end
        end
        if (slot_q == SLOT_END) begin
          slot_d    = '0;
          ch_d      = ch_run_nxt;
          led_d     = LED_ONE << ch_run_nxt;
          dc_comp_d = dc_q[ch_run_nxt];
          pga_d     = gain_q[ch_run_nxt];
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Start overrides whatever RUN was about to do this cycle.
    if (start) begin
      state_d    = DC_ACC;
      ch_d       = '0;
      dc_comp_d  = DC_INIT_C;
      pga_d      = '0;
      led_d      = LED_ONE;
      slot_d     = '0;
      cal_err_d  = '0;
      ch_value_d = ch_value_q;
      valid_d    = '0;
    end

    busy_d     = (state_d == DC_ACC) || (state_d == DC_ADJ) || (state_d == PGA_ACC) ||
                 (state_d == PGA_ADJ) || (state_d == NEXT_CH);
    cal_done_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      dc_comp_q    <= DC_INIT_C;
      pga_q        <= '0;
      led_q        <= '0;
      slot_q       <= '0;
      ch_value_q   <= '0;
      valid_q      <= '0;
      cal_err_q    <= '0;
      busy_q       <= 1'b0;
      cal_done_q   <= 1'b0;
      clk_filter_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        dc_q[k]   <= DC_INIT_C;
        gain_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      dc_comp_q    <= dc_comp_d;
      pga_q        <= pga_d;
      led_q        <= led_d;
      slot_q       <= slot_d;
      ch_value_q   <= ch_value_d;
      valid_q      <= valid_d;
      cal_err_q    <= cal_err_d;
      busy_q       <= busy_d;
      cal_done_q   <= cal_done_d;
      clk_filter_q <= ~clk_filter_q;
      dc_q         <= dc_d;
      gain_q       <= gain_d;
    end
  end

  assign LED_EN      = led_q;
  assign DC_Comp     = dc_comp_q;
  assign PGA_Gain    = pga_q;
  assign CLK_Filter  = clk_filter_q;
  assign Ch_Value    = ch_value_q;
  assign Value_valid = valid_q;
  assign Cal_done    = cal_done_q;
  assign Cal_err     = cal_err_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_led_channel_calibrator.sv
// tb/tb_led_channel_calibrator.sv - scoreboard bench for led_channel_calibrator
module tb_led_channel_calibrator;

  localparam int SL = 10;

  logic        CLK = 1'b0;
  logic        rst;
  always #5 CLK = ~CLK;

  // Instance A: default parameters (two channels)
  logic [7:0]  adc_a;
  logic        find_a;
  logic [1:0]  led_a, val_a, err_a;
  logic [6:0]  dc_a;
  logic [3:0]  pga_a;
  logic        filt_a, done_a, busy_a;
  logic [15:0] chv_a;

  // Instance B: three channels, short slots and windows
  logic [7:0]  adc_b;
  logic        find_b;
  logic [2:0]  led_b, val_b, err_b;
  logic [6:0]  dc_b;
  logic [3:0]  pga_b;
  logic        filt_b, done_b, busy_b;
  logic [23:0] chv_b;

  led_channel_calibrator dut_a (
    .CLK(CLK), .rst(rst), .ADC(adc_a), .Find_setting(find_a),
    .LED_EN(led_a), .DC_Comp(dc_a), .PGA_Gain(pga_a), .CLK_Filter(filt_a),
    .Ch_Value(chv_a), .Value_valid(val_a), .Cal_done(done_a), .Cal_err(err_a), .Busy(busy_a)
  );

  led_channel_calibrator #(.NUM_CH(3), .SLOT_LEN(4), .DC_WIN(4), .PGA_WIN(4)) dut_b (
    .CLK(CLK), .rst(rst), .ADC(adc_b), .Find_setting(find_b),
    .LED_EN(led_b), .DC_Comp(dc_b), .PGA_Gain(pga_b), .CLK_Filter(filt_b),
    .Ch_Value(chv_b), .Value_valid(val_b), .Cal_done(done_b), .Cal_err(err_b), .Busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [1:0] vec;
    logic [7:0] val;
    logic [6:0] dc;
    logic [3:0] gain;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t push_e;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode 0: flat 125. Mode 1: midpoint 80+2*(64-DC) with +/-2 ripple, hard clip to 255
  // on alternate samples once gain reaches 6. Mode 2: stuck at zero.
  function automatic logic [7:0] model(input int mode, input logic [6:0] dc,
                                       input logic [3:0] pga, input int k);
    int mid;
    case (mode)
      0: return 8'd125;
      1: begin
        mid = 80 + 2 * (64 - int'(dc));
        if (pga >= 4'd6 && (k % 2) == 0) return 8'd255;
        return 8'(mid + (((k % 2) != 0) ? 2 : -2));
      end
      default: return 8'd0;
    endcase
  endfunction

  initial forever @(posedge CLK) cyc++;

  // Monitor: every Value_valid pulse on A must match the head of the scoreboard.
  initial forever begin
    @(posedge CLK);
    #1;
    if (mon_en && val_a != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {30'd0, val_a}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("valid_vec", {30'd0, val_a}, {30'd0, mon_e.vec});
        check("valid_cycle", cyc, mon_e.at);
        check("ch_value", {24'd0, chv_a[(mon_e.vec[1] ? 8 : 0) +: 8]}, {24'd0, mon_e.val});
        check("run_led", {30'd0, led_a}, {30'd0, mon_e.vec});
        check("run_dc", {25'd0, dc_a}, {25'd0, mon_e.dc});
        check("run_gain", {28'd0, pga_a}, {28'd0, mon_e.gain});
      end
    end
  end

  task automatic calibrate(input int mode, input int exp_cycles, input logic [6:0] exp_dc,
                           input logic [3:0] exp_gain, input logic [1:0] exp_err, input bit poke);
    int k;
    int ch;
    @(negedge CLK);
    find_a = 1'b1;
    adc_a  = model(mode, dc_a, pga_a, 0);
    @(negedge CLK);
    find_a = 1'b0;
    check("busy_after_start", {31'd0, busy_a}, 32'd1);
    check("led_after_start", {30'd0, led_a}, 32'd1);
    check("done_after_start", {31'd0, done_a}, 32'd0);
    check("err_after_start", {30'd0, err_a}, 32'd0);
    check("dc_after_start", {25'd0, dc_a}, 32'd64);
    k = 0;
    while (!done_a && k < exp_cycles + 300) begin
      adc_a  = model(mode, dc_a, pga_a, k);
      find_a = poke && (k == 500);
      @(negedge CLK);
      k++;
    end
    find_a = 1'b0;
    check("cal_cycles", k, exp_cycles);
    check("cal_err", {30'd0, err_a}, {30'd0, exp_err});
    check("busy_in_run", {31'd0, busy_a}, 32'd0);
    for (int j = 0; j < 4 * SL; j++) begin
      adc_a = 8'(j * 37 + 11);
      if ((j % SL) == SL - 2) begin
        ch          = (j / SL) % 2;
        push_e.vec  = (ch == 1) ? 2'b10 : 2'b01;
        push_e.val  = adc_a;
        push_e.dc   = exp_dc;
        push_e.gain = exp_gain;
        push_e.at   = cyc + 1;
        sb.push_back(push_e);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int ch;
    rst    = 1'b1;
    find_a = 1'b0;
    find_b = 1'b0;
    adc_a  = 8'd0;
    adc_b  = 8'd125;
    repeat (3) @(negedge CLK);
    check("rst_led", {30'd0, led_a}, 32'd0);
    check("rst_dc", {25'd0, dc_a}, 32'd64);
    check("rst_pga", {28'd0, pga_a}, 32'd0);
    check("rst_filter", {31'd0, filt_a}, 32'd0);
    check("rst_chv", {16'd0, chv_a}, 32'd0);
    check("rst_valid", {30'd0, val_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_err", {30'd0, err_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    @(posedge CLK);
    #1;
    check("filter_first", {31'd0, filt_a}, 32'd1);
    @(posedge CLK);
    #1;
    check("filter_second", {31'd0, filt_a}, 32'd0);
    check("idle_led", {30'd0, led_a}, 32'd0);
    mon_en = 1'b1;

    // Flat input, with a Find_setting poke mid-calibration that must be ignored.
    calibrate(0, 1656, 7'd64, 4'd15, 2'b00, 1'b1);
    // Stuck-at-zero input: DC saturates at 0 on both channels, gain clips at 0.
    calibrate(2, 1534, 7'd0, 4'd0, 2'b11, 1'b0);
    // Midpoint model: DC walks 64 down to 49, clip at gain 6 stores 5.
    calibrate(1, 1068, 7'd49, 4'd5, 2'b00, 1'b0);

    // Reset during PGA_ACC of a new calibration.
    @(negedge CLK);
    find_a = 1'b1;
    adc_a  = 8'd125;
    @(negedge CLK);
    find_a = 1'b0;
    repeat (30) @(negedge CLK);
    rst = 1'b1;
    #1;
    check("mid_rst_led", {30'd0, led_a}, 32'd0);
    check("mid_rst_dc", {25'd0, dc_a}, 32'd64);
    check("mid_rst_pga", {28'd0, pga_a}, 32'd0);
    check("mid_rst_filter", {31'd0, filt_a}, 32'd0);
    check("mid_rst_chv", {16'd0, chv_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_done", {31'd0, done_a}, 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("post_rst_busy", {31'd0, busy_a}, 32'd0);
    check("post_rst_led", {30'd0, led_a}, 32'd0);
    calibrate(0, 1656, 7'd64, 4'd15, 2'b00, 1'b0);
    mon_en = 1'b0;
    check("scoreboard_empty", sb.size(), 32'd0);

    // Instance B: three channels, SLOT_LEN=4.
    @(negedge CLK);
    find_b = 1'b1;
    @(negedge CLK);
    find_b = 1'b0;
    k = 0;
    while (!done_b && k < 600) begin
      @(negedge CLK);
      k++;
    end
    check("b_cal_cycles", k, 258);
    for (int j = 0; j < 12; j++) begin
      ch = (j / 4) % 3;
      check("b_led", {29'd0, led_b}, 32'd1 << ch);
      check("b_valid", {29'd0, val_b}, ((j % 4) == 3) ? (32'd1 << ch) : 32'd0);
      if ((j % 4) == 3) check("b_value", {24'd0, chv_b[ch*8 +: 8]}, 32'd125);
      @(negedge CLK);
    end
    check("b_gain", {28'd0, pga_b}, 32'd15);
    find_b = 1'b1;
    @(negedge CLK);
    find_b = 1'b0;
    check("b_restart_busy", {31'd0, busy_b}, 32'd1);
    check("b_restart_led", {29'd0, led_b}, 32'd1);
    check("b_restart_done", {31'd0, done_b}, 32'd0);
    check("b_restart_dc", {25'd0, dc_b}, 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
